wb_io_decoder: RTL and testbench
================================

Name: wb_io_decoder

Overview:
- Pipelined Wishbone (B4) address decoder and response router between the CPU data port and the IO slaves (timer, LEDs, UART, ...).
- Feeds the timer slave directly: one master port, NUM_SLAVES slave ports.
- Decodes the device index, forwards strobes and tracks outstanding requests so responses return in order.
- Routes ack/data back to the master and generates bus errors for unmapped addresses.

Parameters:
- NUM_SLAVES, 4: number of slave ports (1..16).
- BASE_ADDR, 30'h3FFF_F000 (word address): IO region base; bits [29:DEV_LSB+4] must match.
- DEV_LSB, 4: LSB of the 4-bit device index field in i_wb_addr.
- MAX_OUTSTANDING, 8: maximum accepted-but-unacknowledged requests (≤15).
- TIMEOUT_CYCLES, 1024: ack watchdog limit; used only with the optional feature.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  master cycle/strobe/write
- i_wb_addr  in  30  master word address
- i_wb_data  in  32  master write data
- i_wb_sel  in  4  byte selects
- o_wb_ack  out  1  ack to master
- o_wb_stall  out  1  stall to master
- o_wb_err  out  1  bus error to master
- o_wb_data  out  32  read data to master
- o_s_cyc  out  NUM_SLAVES  per-slave cyc
- o_s_stb  out  NUM_SLAVES  per-slave stb
- o_s_we  out  1  broadcast write enable
- o_s_addr  out  30  broadcast address
- o_s_data  out  32  broadcast write data
- o_s_sel  out  4  broadcast byte selects
- i_s_ack  in  NUM_SLAVES  per-slave ack
- i_s_stall  in  NUM_SLAVES  per-slave stall
- i_s_data  in  32*NUM_SLAVES  per-slave read data; slave k occupies bits [32k+31:32k]

Behaviour:
- Decode (combinational):
  - dev = i_wb_addr[DEV_LSB+3:DEV_LSB].
  - mapped = (i_wb_addr[29:DEV_LSB+4] == BASE_ADDR[29:DEV_LSB+4]) && dev < NUM_SLAVES.
- Broadcast: o_s_we/addr/data/sel equal master inputs unregistered.
- State registers: owner (4 bits, the slave with outstanding requests), count (0..MAX_OUTSTANDING), err_pend (1 bit). Reset: count=0, err_pend=0, owner=0.
- Stall: o_wb_stall = i_reset | err_pend | blk | (mapped & i_s_stall[dev]). blk is true when any of:
  - count == MAX_OUTSTANDING
  - count != 0 && mapped && dev != owner
  - !mapped && count != 0
- accept = i_wb_cyc & i_wb_stb & !o_wb_stall.
- o_s_stb[k] = i_wb_cyc & i_wb_stb & mapped & dev==k & !err_pend & !blk & !i_reset. The slave's own stall governs acceptance at the slave.
- o_s_cyc[k] = i_wb_cyc & !i_reset & ((count!=0 & owner==k) | o_s_stb[k]).
- On mapped accept: owner <= dev.
- count update per cycle: count <= count + mapped_accept - (ack_in), where ack_in = i_s_ack[owner] & count!=0. Simultaneous accept and ack leaves count unchanged.
- o_wb_ack = i_wb_cyc & !i_reset & count!=0 & i_s_ack[owner]. Zero-latency pass-through; a slave acking the cycle after strobe (as the timer does) yields master latency 1.
- o_wb_data = i_s_data[owner] when count!=0, else 0.
- Acks from a non-owner slave, or arriving with count==0, are ignored.
- Unmapped accept (only possible with count==0):
  - err_pend <= 1.
  - Next cycle: o_wb_err=1 for exactly one cycle, o_wb_data=0; err_pend clears.
- o_wb_err = err_pend & i_wb_cyc.
- i_wb_cyc low, any cycle: count <= 0, err_pend <= 0, all o_s_cyc/o_s_stb low in that same cycle. In-flight acks are dropped.
- Reset mid-operation: same as cyc drop. o_wb_stall=1, all other outputs 0 during reset.

Optional Feature:
- Macro WB_IO_DECODER_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles while count!=0 with no ack_in; any ack resets it.
  - On reaching TIMEOUT_CYCLES: o_wb_err=1 for one cycle, count <= 0, o_s_cyc[owner] forced low that cycle.
- Undefined: no watchdog. A non-responding mapped slave stalls the master indefinitely.

Test Plan:
- Single read, dev 0 (timer), timer counter=0x1234: one strobe → o_s_stb[0] for one cycle, o_wb_ack next cycle, o_wb_data=0x0000_1234, count returns to 0.
- Three back-to-back pipelined reads to dev 0 → three strobes on consecutive cycles, no stall, three acks in order, count peaks at 1 and is 0 after.
- Read dev 0, then immediately read dev 1 while dev 0's ack is pending → second request stalled until dev 0's ack, then forwarded to o_s_stb[1].
- Access to BASE_ADDR with dev=NUM_SLAVES (4) → no o_s_stb, o_wb_err=1 exactly one cycle later, o_wb_data=0, o_wb_ack never asserted.
- i_s_stall[1] held high for 3 cycles, strobe to dev 1 → o_wb_stall high 3 cycles, request accepted on the 4th, count=1.
- Drop i_wb_cyc with count=2 → o_s_cyc all low that cycle, count=0, a late i_s_ack is not passed to o_wb_ack. With WB_IO_DECODER_TIMEOUT_EN: no ack for 1024 cycles → o_wb_err pulse.

Source files
------------

// File: rtl/wb_io_decoder_if.sv
// rtl/wb_io_decoder_if.sv - CPU-side and IO-side Wishbone signal bundle for wb_io_decoder
interface wb_io_decoder_if #(
  parameter int NUM_SLAVES = 4
);
  logic                       i_wb_cyc;
  logic                       i_wb_stb;
  logic                       i_wb_we;
  logic [29:0]                i_wb_addr;
  logic [31:0]                i_wb_data;
  logic [3:0]                 i_wb_sel;
  logic                       o_wb_ack;
  logic                       o_wb_stall;
  logic                       o_wb_err;
  logic [31:0]                o_wb_data;
  logic [NUM_SLAVES-1:0]      o_s_cyc;
  logic [NUM_SLAVES-1:0]      o_s_stb;
  logic                       o_s_we;
  logic [29:0]                o_s_addr;
  logic [31:0]                o_s_data;
  logic [3:0]                 o_s_sel;
  logic [NUM_SLAVES-1:0]      i_s_ack;
  logic [NUM_SLAVES-1:0]      i_s_stall;
  logic [32*NUM_SLAVES-1:0]   i_s_data;

  // Decoder acting as a Wishbone slave towards the CPU
  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_ack, o_wb_stall, o_wb_err, o_wb_data
  );

  // Decoder acting as a Wishbone master towards the IO slaves
  modport master (
    output o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
    input  i_s_ack, i_s_stall, i_s_data
  );
endinterface

// File: rtl/wb_io_decoder.sv
// rtl/wb_io_decoder.sv - pipelined Wishbone IO address decoder with in-order response routing
// Optional ack watchdog enabled by defining WB_IO_DECODER_TIMEOUT_EN.
module wb_io_decoder #(
  parameter int          NUM_SLAVES      = 4,
  parameter logic [29:0] BASE_ADDR       = 30'h3FFF_F000,
  parameter int          DEV_LSB         = 4,
  parameter int          MAX_OUTSTANDING = 8,
  parameter int          TIMEOUT_CYCLES  = 1024
) (
  input  logic           i_clk,
  input  logic           i_reset,
  wb_io_decoder_if.slave  cpu,
  wb_io_decoder_if.master io
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 ||
      TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wb_io_decoder: parameter out of range");
  end

  logic [3:0]  owner;
  logic [3:0]  count;
  logic        err_pend;

  logic [3:0]  dev;
  logic        mapped;
  logic        busy;
  logic        blk;
  logic        stall;
  logic        req;
  logic        accept;
  logic        mapped_accept;
  logic        unmapped_accept;
  logic        ack_in;
  logic        fwd;
  logic        timeout_hit;
  logic [15:0] ack16;
  logic [15:0] stall16;
  logic [31:0] rdata;

  assign dev    = cpu.i_wb_addr[DEV_LSB+3:DEV_LSB];
  assign mapped = (cpu.i_wb_addr[29:DEV_LSB+4] == BASE_ADDR[29:DEV_LSB+4]) &&
                  ({1'b0, dev} < 5'(NUM_SLAVES));
  assign busy   = (count != 4'd0);

  // Zero-extended copies let dev/owner index safely when NUM_SLAVES < 16
  always_comb begin
    ack16   = '0;
    stall16 = '0;
    rdata   = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      ack16[k]   = io.i_s_ack[k];
      stall16[k] = io.i_s_stall[k];
      if (owner == 4'(k)) rdata = io.i_s_data[32*k +: 32];
    end
  end

  assign blk = (count == 4'(MAX_OUTSTANDING)) |
               (busy & mapped & (dev != owner)) |
               (!mapped & busy);
  assign ack_in          = ack16[owner] & busy;
  assign stall           = i_reset | err_pend | blk | (mapped & stall16[dev]) | timeout_hit;
  assign req             = cpu.i_wb_cyc & cpu.i_wb_stb;
  assign accept          = req & !stall;
  assign mapped_accept   = accept & mapped;
  assign unmapped_accept = accept & !mapped;
  assign fwd             = req & mapped & !err_pend & !blk & !i_reset & !timeout_hit;

`ifdef WB_IO_DECODER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;

  assign timeout_hit = busy & !ack_in & (wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || !cpu.i_wb_cyc || !busy || ack_in || timeout_hit) wd <= '0;
    else                                                            wd <= wd + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count    <= 4'd0;
      err_pend <= 1'b0;
      owner    <= 4'd0;
    end else if (!cpu.i_wb_cyc) begin
      count    <= 4'd0;
      err_pend <= 1'b0;
    end else begin
      if (mapped_accept) owner <= dev;
      err_pend <= unmapped_accept;
      if (timeout_hit) count <= 4'd0;
      else             count <= count + {3'b0, mapped_accept} - {3'b0, ack_in};
    end
  end

  always_comb begin
    io.o_s_stb = '0;
    io.o_s_cyc = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      io.o_s_stb[k] = fwd & (dev == 4'(k));
      io.o_s_cyc[k] = cpu.i_wb_cyc & !i_reset &
                      ((busy & (owner == 4'(k)) & !timeout_hit) | io.o_s_stb[k]);
    end
  end

  assign io.o_s_we   = cpu.i_wb_we & !i_reset;
  assign io.o_s_addr = i_reset ? 30'd0 : cpu.i_wb_addr;
  assign io.o_s_data = i_reset ? 32'd0 : cpu.i_wb_data;
  assign io.o_s_sel  = i_reset ? 4'd0  : cpu.i_wb_sel;

  assign cpu.o_wb_stall = stall;
  assign cpu.o_wb_ack   = cpu.i_wb_cyc & !i_reset & ack_in;
  assign cpu.o_wb_err   = cpu.i_wb_cyc & !i_reset & (err_pend | timeout_hit);
  assign cpu.o_wb_data  = (!i_reset && busy) ? rdata : 32'd0;

endmodule

// File: tb/tb_wb_io_decoder.sv
// tb/tb_wb_io_decoder.sv - randomized and directed self-checking bench for wb_io_decoder
module tb_wb_io_decoder;
  localparam int          N    = 4;
  localparam logic [29:0] BASE = 30'h3FFF_F000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [3:0]  ack_hold = '0;
  logic [3:0]  ack_r    = '0;
  logic        flush    = 1'b0;
  logic [31:0] dat_r [N];
  logic [31:0] sq [N][$];

  always #5 clk = ~clk;

  wb_io_decoder_if #(.NUM_SLAVES(N)) bus ();

  wb_io_decoder #(
    .NUM_SLAVES(N), .BASE_ADDR(BASE), .DEV_LSB(4), .MAX_OUTSTANDING(8), .TIMEOUT_CYCLES(1024)
  ) dut (
    .i_clk(clk), .i_reset(rst), .cpu(bus), .io(bus)
  );

  function automatic logic [31:0] slave_data(int k, logic [29:0] a);
    return (k == 0) ? 32'h0000_1234 : {4'hA, 4'(k), a[23:0]};
  endfunction

  function automatic logic [29:0] mk_addr(int d, int off);
    return (BASE & 30'h3FFF_FF00) | 30'((d & 15) << 4) | 30'(off & 15);
  endfunction

  function automatic bit model_mapped(logic [29:0] a);
    return ((a >> 8) == (BASE >> 8)) && (((a >> 4) & 30'd15) < N);
  endfunction

  // Slave models: one-cycle-latency pipelined responders with a per-slave ack hold
  assign bus.i_s_ack = ack_r;
  for (genvar g = 0; g < N; g++) begin : g_sdata
    assign bus.i_s_data[32*g +: 32] = dat_r[g];
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst || flush) sq[k].delete();
      else begin
        if (ack_r[k]) void'(sq[k].pop_front());
        if (bus.o_s_cyc[k] && bus.o_s_stb[k] && !bus.i_s_stall[k])
          sq[k].push_back(slave_data(k, bus.o_s_addr));
      end
      ack_r[k] <= (sq[k].size() != 0) && !ack_hold[k];
      dat_r[k] <= (sq[k].size() != 0) ? sq[k][0] : 32'd0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    bus.i_wb_addr = '0; bus.i_wb_data = '0; bus.i_wb_sel = '0; bus.i_s_stall = '0;
    repeat (3) step();
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_addr = mk_addr(0, 0);
    bus.i_wb_data = 32'hDEAD_BEEF; bus.i_wb_sel = 4'hF;
    sample();
    checks++; if (bus.o_wb_stall !== 1'b1) begin errors++; $display("FAIL reset_stall got=%0h exp=1", bus.o_wb_stall); end
    checks++; if (bus.o_wb_ack !== 1'b0 || bus.o_wb_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err got=%0b%0b exp=00", bus.o_wb_ack, bus.o_wb_err); end
    checks++; if (bus.o_s_stb !== 4'h0 || bus.o_s_cyc !== 4'h0) begin errors++; $display("FAIL reset_s_cyc_stb got=%0h/%0h exp=0/0", bus.o_s_cyc, bus.o_s_stb); end
    checks++; if (bus.o_wb_data !== 32'h0 || bus.o_s_addr !== 30'h0) begin errors++; $display("FAIL reset_data got=%0h/%0h exp=0/0", bus.o_wb_data, bus.o_s_addr); end
    step();
    rst = 1'b0; bus.i_wb_stb = 1'b0;
    sample();
    checks++; if (bus.o_wb_stall !== 1'b0 || bus.o_s_cyc !== 4'h0) begin errors++; $display("FAIL idle_after_reset got=%0h/%0h exp=0/0", bus.o_wb_stall, bus.o_s_cyc); end
    checks++; if (bus.o_s_data !== 32'hDEAD_BEEF || bus.o_s_sel !== 4'hF) begin errors++; $display("FAIL broadcast got=%0h/%0h exp=deadbeef/f", bus.o_s_data, bus.o_s_sel); end
  endtask

  task automatic test_single_read();
    step(); bus.i_wb_stb = 1'b1; bus.i_wb_addr = mk_addr(0, 1);
    sample();
    checks++; if (bus.o_s_stb !== 4'b0001 || bus.o_wb_stall !== 1'b0) begin errors++; $display("FAIL single_stb got=%0h/%0h exp=1/0", bus.o_s_stb, bus.o_wb_stall); end
    step(); bus.i_wb_stb = 1'b0;
    sample();
    checks++; if (bus.o_wb_ack !== 1'b1 || bus.o_wb_data !== 32'h0000_1234) begin errors++; $display("FAIL single_ack got=%0h/%0h exp=1/1234", bus.o_wb_ack, bus.o_wb_data); end
    checks++; if (bus.o_s_stb !== 4'h0) begin errors++; $display("FAIL single_stb_once got=%0h exp=0", bus.o_s_stb); end
    step(); sample();
    checks++; if (bus.o_wb_ack !== 1'b0 || bus.o_s_cyc !== 4'h0) begin errors++; $display("FAIL single_idle got=%0h/%0h exp=0/0", bus.o_wb_ack, bus.o_s_cyc); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      step(); bus.i_wb_stb = (i < 3); bus.i_wb_addr = mk_addr(0, i);
      sample();
      checks++; if (bus.o_s_stb !== ((i < 3) ? 4'b0001 : 4'b0000) || bus.o_wb_stall !== 1'b0) begin errors++; $display("FAIL b2b_stb[%0d] got=%0h/%0h exp=%0h/0", i, bus.o_s_stb, bus.o_wb_stall, (i < 3) ? 1 : 0); end
      checks++; if (bus.o_wb_ack !== (i >= 1 && i <= 3) || (bus.o_wb_ack && bus.o_wb_data !== 32'h1234)) begin errors++; $display("FAIL b2b_ack[%0d] got=%0h/%0h exp=%0b/1234", i, bus.o_wb_ack, bus.o_wb_data, (i >= 1 && i <= 3)); end
    end
    checks++; if (bus.o_s_cyc !== 4'h0) begin errors++; $display("FAIL b2b_count_zero got=%0h exp=0", bus.o_s_cyc); end
  endtask

  task automatic test_dev_switch();
    step(); ack_hold[0] = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_addr = mk_addr(0, 2);
    sample();
    checks++; if (bus.o_s_stb !== 4'b0001) begin errors++; $display("FAIL switch_first got=%0h exp=1", bus.o_s_stb); end
    for (int c = 1; c <= 2; c++) begin
      step(); bus.i_wb_addr = mk_addr(1, 3); if (c == 2) ack_hold[0] = 1'b0;
      sample();
      checks++; if (bus.o_wb_stall !== 1'b1 || bus.o_s_stb !== 4'h0 || bus.o_wb_ack !== 1'b0) begin errors++; $display("FAIL switch_wait[%0d] got=%0b/%0h/%0b exp=1/0/0", c, bus.o_wb_stall, bus.o_s_stb, bus.o_wb_ack); end
    end
    step(); sample();
    checks++; if (bus.o_wb_ack !== 1'b1 || bus.o_wb_data !== 32'h1234 || bus.o_wb_stall !== 1'b1) begin errors++; $display("FAIL switch_ack0 got=%0b/%0h/%0b exp=1/1234/1", bus.o_wb_ack, bus.o_wb_data, bus.o_wb_stall); end
    step(); sample();
    checks++; if (bus.o_wb_stall !== 1'b0 || bus.o_s_stb !== 4'b0010) begin errors++; $display("FAIL switch_fwd1 got=%0b/%0h exp=0/2", bus.o_wb_stall, bus.o_s_stb); end
    step(); bus.i_wb_stb = 1'b0; sample();
    checks++; if (bus.o_wb_ack !== 1'b1 || bus.o_wb_data !== slave_data(1, mk_addr(1, 3))) begin errors++; $display("FAIL switch_ack1 got=%0b/%0h exp=1/%0h", bus.o_wb_ack, bus.o_wb_data, slave_data(1, mk_addr(1, 3))); end
  endtask

  task automatic test_unmapped();
    logic [29:0] addrs [2];
    addrs[0] = mk_addr(N, 0);
    addrs[1] = 30'h0000_0010;
    for (int i = 0; i < 2; i++) begin
      step(); bus.i_wb_stb = 1'b1; bus.i_wb_addr = addrs[i];
      sample();
      checks++; if (bus.o_s_stb !== 4'h0 || bus.o_wb_stall !== 1'b0) begin errors++; $display("FAIL unmapped_stb[%0d] got=%0h/%0b exp=0/0", i, bus.o_s_stb, bus.o_wb_stall); end
      step(); bus.i_wb_stb = 1'b0; sample();
      checks++; if (bus.o_wb_err !== 1'b1 || bus.o_wb_data !== 32'h0 || bus.o_wb_ack !== 1'b0) begin errors++; $display("FAIL unmapped_err[%0d] got=%0b/%0h/%0b exp=1/0/0", i, bus.o_wb_err, bus.o_wb_data, bus.o_wb_ack); end
      step(); sample();
      checks++; if (bus.o_wb_err !== 1'b0 || bus.o_wb_ack !== 1'b0) begin errors++; $display("FAIL unmapped_once[%0d] got=%0b/%0b exp=0/0", i, bus.o_wb_err, bus.o_wb_ack); end
    end
  endtask

  task automatic test_slave_stall();
    for (int i = 0; i < 4; i++) begin
      step(); bus.i_wb_stb = 1'b1; bus.i_wb_addr = mk_addr(1, 5);
      bus.i_s_stall = (i < 3) ? 4'b0010 : 4'b0000;
      sample();
      checks++; if (bus.o_wb_stall !== (i < 3) || bus.o_s_stb !== 4'b0010) begin errors++; $display("FAIL sstall[%0d] got=%0b/%0h exp=%0b/2", i, bus.o_wb_stall, bus.o_s_stb, (i < 3)); end
    end
    step(); bus.i_wb_stb = 1'b0; sample();
    checks++; if (bus.o_s_cyc !== 4'b0010 || bus.o_wb_ack !== 1'b1 || bus.o_wb_data !== slave_data(1, mk_addr(1, 5))) begin errors++; $display("FAIL sstall_ack got=%0h/%0b/%0h exp=2/1/%0h", bus.o_s_cyc, bus.o_wb_ack, bus.o_wb_data, slave_data(1, mk_addr(1, 5))); end
    step(); sample();
    checks++; if (bus.o_s_cyc !== 4'h0 || bus.o_wb_ack !== 1'b0) begin errors++; $display("FAIL sstall_idle got=%0h/%0b exp=0/0", bus.o_s_cyc, bus.o_wb_ack); end
  endtask

  task automatic test_cyc_drop();
    for (int c = 0; c < 2; c++) begin
      step(); ack_hold[1] = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_addr = mk_addr(1, c);
      sample();
      checks++; if (bus.o_s_stb !== 4'b0010 || bus.o_wb_stall !== 1'b0) begin errors++; $display("FAIL drop_issue[%0d] got=%0h/%0b exp=2/0", c, bus.o_s_stb, bus.o_wb_stall); end
    end
    step(); bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; ack_hold[1] = 1'b0;
    sample();
    checks++; if (bus.o_s_cyc !== 4'h0 || bus.o_s_stb !== 4'h0 || bus.o_wb_ack !== 1'b0) begin errors++; $display("FAIL drop_cyc got=%0h/%0h/%0b exp=0/0/0", bus.o_s_cyc, bus.o_s_stb, bus.o_wb_ack); end
    step(); bus.i_wb_cyc = 1'b1; flush = 1'b1;
    sample();
    checks++; if (bus.o_wb_ack !== 1'b0 || bus.o_s_cyc !== 4'h0) begin errors++; $display("FAIL drop_late_ack got=%0b/%0h exp=0/0", bus.o_wb_ack, bus.o_s_cyc); end
    step(); flush = 1'b0; sample();
    checks++; if (bus.o_wb_ack !== 1'b0 || bus.o_wb_stall !== 1'b0) begin errors++; $display("FAIL drop_idle got=%0b/%0b exp=0/0", bus.o_wb_ack, bus.o_wb_stall); end
  endtask

`ifdef WB_IO_DECODER_TIMEOUT_EN
  task automatic test_timeout();
    int         found;
    logic [3:0] cyc_at;
    found  = -1;
    cyc_at = 4'hF;
    step(); ack_hold[0] = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_addr = mk_addr(0, 7);
    sample();
    for (int i = 1; i <= 1200 && found < 0; i++) begin
      step(); bus.i_wb_stb = 1'b0; sample();
      if (bus.o_wb_err === 1'b1) begin found = i; cyc_at = bus.o_s_cyc; end
    end
    checks++; if (found != 1024) begin errors++; $display("FAIL timeout_cycle got=%0d exp=1024", found); end
    checks++; if (cyc_at !== 4'h0) begin errors++; $display("FAIL timeout_cyc_low got=%0h exp=0", cyc_at); end
    step(); flush = 1'b1; ack_hold[0] = 1'b0; sample();
    checks++; if (bus.o_wb_err !== 1'b0 || bus.o_s_cyc !== 4'h0) begin errors++; $display("FAIL timeout_clear got=%0b/%0h exp=0/0", bus.o_wb_err, bus.o_s_cyc); end
    step(); flush = 1'b0; sample();
  endtask
`endif

  task automatic test_random();
    logic [32:0] expq [$];
    logic [32:0] e;
    bit          pending;
    bit          mp;
    int          d;
    pending = 1'b0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      step();
      if (cyc < 600) begin
        if (!pending) begin
          bus.i_wb_stb = ($urandom_range(0, 3) != 0);
          bus.i_wb_we  = $urandom_range(0, 1);
          bus.i_wb_addr = ($urandom_range(0, 9) == 0) ? 30'($urandom)
                                                      : mk_addr($urandom_range(0, 5), $urandom_range(0, 15));
        end
        bus.i_s_stall = 4'($urandom) & 4'($urandom);
        ack_hold      = 4'($urandom) & 4'($urandom) & 4'($urandom);
      end else begin
        bus.i_wb_stb = pending; bus.i_s_stall = '0; ack_hold = '0;
      end
      sample();
      if (bus.o_wb_ack || bus.o_wb_err) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected_resp ack=%0b err=%0b exp=none", bus.o_wb_ack, bus.o_wb_err);
        end else begin
          e = expq.pop_front();
          if (bus.o_wb_ack === bus.o_wb_err || bus.o_wb_err !== e[32] || bus.o_wb_data !== e[31:0]) begin
            errors++; $display("FAIL rnd_resp got=err%0b/ack%0b/%0h exp=err%0b/%0h", bus.o_wb_err, bus.o_wb_ack, bus.o_wb_data, e[32], e[31:0]);
          end
        end
      end
      if (bus.i_wb_stb && !bus.o_wb_stall) begin
        mp = model_mapped(bus.i_wb_addr);
        d  = int'((bus.i_wb_addr >> 4) & 30'd15);
        expq.push_back(mp ? {1'b0, slave_data(d, bus.i_wb_addr)} : 33'h1_0000_0000);
        checks++;
        if (bus.o_s_stb !== (mp ? 4'(1 << d) : 4'h0)) begin
          errors++; $display("FAIL rnd_route addr=%0h got=%0h exp=%0h", bus.i_wb_addr, bus.o_s_stb, mp ? 4'(1 << d) : 4'h0);
        end
        pending = 1'b0;
      end else begin
        pending = bus.i_wb_stb;
      end
    end
    checks++; if (expq.size() != 0 || pending) begin errors++; $display("FAIL rnd_drain left=%0d pending=%0b exp=0/0", expq.size(), pending); end
    step(); bus.i_wb_stb = 1'b0; sample();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_dev_switch();
    test_unmapped();
    test_slave_stall();
    test_cyc_drop();
`ifdef WB_IO_DECODER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
